// File: rtl/data_memory_pkg.sv
// Shared types and sizing helpers for the parametrised data memory.
package data_memory_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } mem_state_t;

  function automatic int lane_count(input int data_width, input int lane_width);
    return data_width / lane_width;
  endfunction

  // Word index width; a single-word memory still needs one bit to index it.
  function automatic int index_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_clear_sweeper.sv
// Clear/idle controller: owns the sweep pointer, ready, addr_error and the array write-port mux.
module mem_clear_sweeper
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 1,
  parameter int DEPTH      = 256,
  parameter int IDX_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  write_enable,
  input  logic                  addr_ok,
  input  logic [LANES-1:0]      write_mask,
  input  logic [IDX_W-1:0]      index,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  wr_en,
  output logic [IDX_W-1:0]      wr_idx,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [LANES-1:0]      wr_lanes,
  output logic                  ready,
  output logic                  addr_error
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  mem_state_t       state;
  logic [IDX_W-1:0] ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_CLEAR;
      ptr        <= '0;
      ready      <= 1'b0;
      addr_error <= 1'b0;
    end else begin
      addr_error <= 1'b0;
      case (state)
        ST_CLEAR: begin
          if (ptr == LAST) begin
            state <= ST_IDLE;
            ptr   <= '0;
            ready <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        ST_IDLE: begin
          // clear wins over a same-cycle write, which is then dropped silently
          if (clear) begin
            state <= ST_CLEAR;
            ready <= 1'b0;
          end else if (write_enable && !addr_ok) begin
            addr_error <= 1'b1;
          end
        end
        default: begin
          state <= ST_CLEAR;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Sweep zero-write takes the port while clearing; otherwise the masked user write.
  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = index;
    wr_data  = data_in;
    wr_lanes = write_mask;
    if (state == ST_CLEAR) begin
      wr_en    = 1'b1;
      wr_idx   = ptr;
      wr_data  = '0;
      wr_lanes = '1;
    end else begin
      wr_en = write_enable && addr_ok && !clear;
    end
  end

endmodule

// File: rtl/data_memory_param.sv
// Parametrised lane-masked data memory with swept clear and optional registered read.
module data_memory_param
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int LANE_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 0
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         clear,
  input  logic                                         write_enable,
  input  logic [lane_count(DATA_WIDTH, LANE_WIDTH)-1:0] write_mask,
  input  logic [ADDR_WIDTH-1:0]                        address,
  input  logic [DATA_WIDTH-1:0]                        data_in,
  output logic [DATA_WIDTH-1:0]                        data_out,
  output logic                                         ready,
  output logic                                         addr_error
);

  localparam int LANES = lane_count(DATA_WIDTH, LANE_WIDTH);
  localparam int IDX_W = index_width(DEPTH);

  logic                  addr_ok;
  logic [IDX_W-1:0]      rd_idx;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [LANES-1:0]      wr_lanes;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // One extra compare bit so DEPTH == 2**ADDR_WIDTH is representable.
  assign addr_ok = ({1'b0, address} < (ADDR_WIDTH + 1)'(DEPTH));
  assign rd_idx  = address[IDX_W-1:0];

  mem_clear_sweeper #(
    .DATA_WIDTH(DATA_WIDTH),
    .LANES     (LANES),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W)
  ) u_sweeper (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .write_enable(write_enable),
    .addr_ok     (addr_ok),
    .write_mask  (write_mask),
    .index       (rd_idx),
    .data_in     (data_in),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_data     (wr_data),
    .wr_lanes    (wr_lanes),
    .ready       (ready),
    .addr_error  (addr_error)
  );

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_lanes[i]) begin
          mem[wr_idx][i*LANE_WIDTH +: LANE_WIDTH] <= wr_data[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  if (READ_LATENCY == 1) begin : g_reg_read
    logic [DATA_WIDTH-1:0] rd_data_p1;

    // ready mirrors ST_IDLE, so it gates the read-before-write sample.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_data_p1 <= '0;
      end else begin
        rd_data_p1 <= (ready && addr_ok) ? mem[rd_idx] : '0;
      end
    end

    assign data_out = rd_data_p1;
  end else begin : g_comb_read
    assign data_out = (ready && addr_ok) ? mem[rd_idx] : '0;
  end

endmodule

// File: tb/tb_data_memory_param.sv
// Bench for data_memory_param: an 8x256 combinational-read instance and a 32x200 registered-read instance.
module tb_data_memory_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        write_enable = 1'b0;
  logic [3:0]  mask = 4'b0;
  logic [7:0]  address = 8'h0;
  logic [31:0] data_in = 32'h0;

  logic [7:0]  d0;
  logic [31:0] d1;
  logic        ready0, ready1, err0, err1;

  int nchecks = 0;
  int nerrors = 0;

  // Reference model: memory contents plus remaining sweep edges per instance.
  logic [7:0]  m0 [256];
  logic [31:0] m1 [200];
  int          left0, left1;
  logic        err0m, err1m;
  logic [31:0] dr1;

  typedef struct {
    logic        we;
    logic [3:0]  msk;
    logic [7:0]  addr;
    logic [31:0] din;
    logic        clr;
    logic [7:0]  e0;
    logic [31:0] e1;
    logic        ee1;
  } vec_t;

  vec_t vt[13];

  always #5 clk = ~clk;

  data_memory_param #(
    .DATA_WIDTH(8), .LANE_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256), .READ_LATENCY(0)
  ) dut0 (
    .clk(clk), .reset(reset), .clear(clear), .write_enable(write_enable),
    .write_mask(mask[0:0]), .address(address), .data_in(data_in[7:0]),
    .data_out(d0), .ready(ready0), .addr_error(err0)
  );

  data_memory_param #(
    .DATA_WIDTH(32), .LANE_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(200), .READ_LATENCY(1)
  ) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .write_enable(write_enable),
    .write_mask(mask), .address(address), .data_in(data_in),
    .data_out(d1), .ready(ready1), .addr_error(err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m0[i] = 8'h0;
    for (int i = 0; i < 200; i++) m1[i] = 32'h0;
    left0 = 256;
    left1 = 200;
    err0m = 1'b0;
    err1m = 1'b0;
    dr1   = 32'h0;
  endtask

  task automatic model_edge();
    if (reset) return;
    err0m = 1'b0;
    err1m = 1'b0;
    if (left0 > 0) begin
      left0--;
    end else if (clear) begin
      left0 = 256;
      for (int i = 0; i < 256; i++) m0[i] = 8'h0;
    end else if (write_enable && mask[0]) begin
      m0[address] = data_in[7:0];
    end
    if (left1 > 0) begin
      left1--;
      dr1 = 32'h0;
    end else begin
      if (address < 200) dr1 = m1[address];
      else dr1 = 32'h0;
      if (clear) begin
        left1 = 200;
        for (int i = 0; i < 200; i++) m1[i] = 32'h0;
      end else if (write_enable) begin
        if (address < 200) begin
          for (int l = 0; l < 4; l++)
            if (mask[l]) m1[address][8*l +: 8] = data_in[8*l +: 8];
        end else begin
          err1m = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [7:0] e0;
    e0 = (left0 == 0) ? m0[address] : 8'h0;
    chk("ready0", {31'h0, ready0}, {31'h0, left0 == 0});
    chk("ready1", {31'h0, ready1}, {31'h0, left1 == 0});
    chk("addr_error0", {31'h0, err0}, {31'h0, err0m});
    chk("addr_error1", {31'h0, err1}, {31'h0, err1m});
    chk("data_out0", {24'h0, d0}, {24'h0, e0});
    chk("data_out1", d1, dr1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic we, input logic [3:0] msk, input logic [7:0] addr,
                       input logic [31:0] din, input logic clr);
    write_enable = we;
    mask         = msk;
    address      = addr;
    data_in      = din;
    clear        = clr;
  endtask

  initial begin
    vt[0]  = '{1'b1, 4'b0001, 8'h10, 32'h000000A5, 1'b0, 8'hA5, 32'h00000000, 1'b0};
    vt[1]  = '{1'b0, 4'b0000, 8'h10, 32'h00000000, 1'b0, 8'hA5, 32'h000000A5, 1'b0};
    vt[2]  = '{1'b1, 4'b1111, 8'h03, 32'h11223344, 1'b0, 8'h44, 32'h00000000, 1'b0};
    vt[3]  = '{1'b1, 4'b0101, 8'h03, 32'hFFFFFFFF, 1'b0, 8'hFF, 32'h11223344, 1'b0};
    vt[4]  = '{1'b0, 4'b0000, 8'h03, 32'h00000000, 1'b0, 8'hFF, 32'h11FF33FF, 1'b0};
    vt[5]  = '{1'b1, 4'b1111, 8'd250, 32'hDEADBEEF, 1'b0, 8'hEF, 32'h00000000, 1'b1};
    vt[6]  = '{1'b0, 4'b0000, 8'd250, 32'h00000000, 1'b0, 8'hEF, 32'h00000000, 1'b0};
    vt[7]  = '{1'b1, 4'b0000, 8'h03, 32'h00000000, 1'b0, 8'hFF, 32'h11FF33FF, 1'b0};
    vt[8]  = '{1'b1, 4'b1110, 8'h10, 32'h12345678, 1'b0, 8'hA5, 32'h000000A5, 1'b0};
    vt[9]  = '{1'b0, 4'b0000, 8'h10, 32'h00000000, 1'b0, 8'hA5, 32'h123456A5, 1'b0};
    vt[10] = '{1'b1, 4'b1111, 8'd220, 32'h00000042, 1'b0, 8'h42, 32'h00000000, 1'b1};
    vt[11] = '{1'b1, 4'b1111, 8'd201, 32'h00000055, 1'b0, 8'h55, 32'h00000000, 1'b1};
    vt[12] = '{1'b0, 4'b0000, 8'd220, 32'h00000000, 1'b0, 8'h42, 32'h00000000, 1'b0};

    // Reset state and the initial sweep.
    model_reset();
    #1;
    chk("reset_ready0", {31'h0, ready0}, 32'h0);
    chk("reset_ready1", {31'h0, ready1}, 32'h0);
    chk("reset_err1", {31'h0, err1}, 32'h0);
    chk("reset_dout1", d1, 32'h0);
    repeat (2) tick();
    reset = 1'b0;
    for (int i = 0; i < 255; i++) begin
      address = 8'($urandom_range(0, 255));
      tick();
    end
    chk("sweep_ready0_at_255", {31'h0, ready0}, 32'h0);
    chk("sweep_ready1_done", {31'h0, ready1}, 32'h1);
    tick();
    chk("sweep_ready0_at_256", {31'h0, ready0}, 32'h1);

    // Directed vectors: lane masking, read latency, out-of-range writes.
    foreach (vt[i]) begin
      drive(vt[i].we, vt[i].msk, vt[i].addr, vt[i].din, vt[i].clr);
      tick();
      chk($sformatf("vec%0d_dout0", i), {24'h0, d0}, {24'h0, vt[i].e0});
      chk($sformatf("vec%0d_dout1", i), d1, vt[i].e1);
      chk($sformatf("vec%0d_err1", i), {31'h0, err1}, {31'h0, vt[i].ee1});
    end

    // Clear with a same-cycle write, then writes during the sweep.
    drive(1'b1, 4'b1111, 8'd5, 32'h00000077, 1'b0);
    tick();
    drive(1'b1, 4'b1111, 8'd6, 32'h00000099, 1'b1);
    tick();
    chk("clear_ready0_low", {31'h0, ready0}, 32'h0);
    clear = 1'b0;
    for (int i = 0; i < 255; i++) begin
      drive(1'b1, 4'($urandom), 8'($urandom_range(0, 255)), $urandom, 1'b0);
      tick();
    end
    chk("clear_ready0_still_low", {31'h0, ready0}, 32'h0);
    drive(1'b0, 4'b0000, 8'd5, 32'h0, 1'b0);
    tick();
    chk("clear_ready0_back", {31'h0, ready0}, 32'h1);
    chk("clear_addr5_zero", {24'h0, d0}, 32'h0);
    address = 8'd6;
    tick();
    chk("clear_addr6_zero", {24'h0, d0}, 32'h0);

    // Reset at sweep cycle 100 restarts the full sweep.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (100) tick();
    reset = 1'b1;
    model_reset();
    #1;
    chk("midreset_ready0", {31'h0, ready0}, 32'h0);
    chk("midreset_dout1", d1, 32'h0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (255) tick();
    chk("midreset_ready0_at_255", {31'h0, ready0}, 32'h0);
    tick();
    chk("midreset_ready0_at_256", {31'h0, ready0}, 32'h1);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom),
            ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255)),
            $urandom, ($urandom_range(0, 149) == 0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
